// File: rtl/narvie_pkg.sv
// Shared encodings and sizes for the host-side UART link and its byte receiver.
package narvie_pkg;

  localparam int B115200    = 104;
  localparam int DUMP_BYTES = 128;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND, TX_WAIT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling, byte strobe or framing-error pulse.
module uart_rx_byte
  import narvie_pkg::*;
#(
  parameter int BAUDRATE = B115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       strobe,
  output logic       frame_err
);

  rx_state_t   state, state_d;
  logic [1:0]  sync;
  logic        line, line_prev;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shreg, shreg_d;
  logic        strobe_d, ferr_d;

  assign line = sync[1];
  assign data = shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 2'b11;
      line_prev <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= 16'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      strobe    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      line_prev <= line;
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_idx_d;
      shreg     <= shreg_d;
      strobe    <= strobe_d;
      frame_err <= ferr_d;
    end
  end

  // A start needs a falling edge, so a low stop bit cannot be mistaken for the next start.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + 16'd1;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    strobe_d  = 1'b0;
    ferr_d    = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_d = 16'd0;
        if (line_prev && !line) state_d = RX_START;
      end
      RX_START: begin
        if (cnt == 16'(BAUDRATE / 2 - 1)) begin
          cnt_d     = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == 16'(BAUDRATE - 1)) begin
          cnt_d     = 16'd0;
          shreg_d   = {line, shreg[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == 16'(BAUDRATE - 1)) begin
          state_d  = RX_IDLE;
          strobe_d = line;
          ferr_d   = !line;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte on start while ready, shifts it out LSB first.
module uart_tx #(
  parameter int BAUDRATE = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  logic [9:0]  shreg;
  logic [3:0]  bits_left;
  logic [15:0] baud_cnt;

  assign ready = (bits_left == 4'd0);
  assign tx    = shreg[0];

  // Idle line is all ones in the shifter, so tx sits high whenever nothing is queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '1;
      bits_left <= 4'd0;
      baud_cnt  <= 16'd0;
    end else if (ready) begin
      baud_cnt <= 16'd0;
      if (start) begin
        shreg     <= {1'b1, data, 1'b0};
        bits_left <= 4'd10;
      end
    end else if (baud_cnt == 16'(BAUDRATE - 1)) begin
      baud_cnt  <= 16'd0;
      shreg     <= {1'b1, shreg[9:1]};
      bits_left <= bits_left - 4'd1;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_host_link.sv
// Host-side stand-in: sends a 32-bit instruction as 4 UART bytes, then rebuilds the
// 128-byte register dump that comes back into a readable 32x32 image.
module uart_host_link
  import narvie_pkg::*;
#(
  parameter int BAUDRATE       = B115200,
  parameter int TIMEOUT_CYCLES = 12_000_000
) (
  input  logic        clk12,
  input  logic        rstn,
  input  logic        rx,
  output logic        tx,
  input  logic [31:0] inst_data,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        dump_busy,
  output logic        dump_done,
  output logic        timeout,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  tx_state_t   tx_state, tx_state_d;
  logic [31:0] word;
  logic [1:0]  tx_cnt;
  logic        alive;
  logic        tx_start, tx_ready;
  logic [7:0]  tx_byte;
  logic        handshake, last_sent;

  logic [7:0]    rx_byte;
  logic          rx_strobe;
  logic [6:0]    byte_idx;
  logic [TW-1:0] tmo_cnt;
  logic          timeout_hit, accept, last_byte;
  logic [31:0]   image [NUM_REGS];

  // alive keeps inst_ready low while reset is held.
  assign inst_ready  = alive && (tx_state == TX_IDLE) && !dump_busy;
  assign handshake   = inst_valid && inst_ready;
  assign last_sent   = (tx_state == TX_WAIT) && tx_ready && (tx_cnt == 2'd3);
  assign timeout_hit = dump_busy && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign accept      = rx_strobe && dump_busy && !timeout_hit;
  assign last_byte   = accept && (byte_idx == 7'(DUMP_BYTES - 1));

  uart_tx #(.BAUDRATE(BAUDRATE)) u_tx (
    .clk   (clk12),
    .rst_n (rstn),
    .start (tx_start),
    .data  (tx_byte),
    .tx    (tx),
    .ready (tx_ready)
  );

  uart_rx_byte #(.BAUDRATE(BAUDRATE)) u_rx (
    .clk       (clk12),
    .rst_n     (rstn),
    .rx        (rx),
    .data      (rx_byte),
    .strobe    (rx_strobe),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
      word     <= 32'd0;
      tx_cnt   <= 2'd0;
      alive    <= 1'b0;
    end else begin
      alive    <= 1'b1;
      tx_state <= tx_state_d;
      if (handshake) begin
        word   <= inst_data;
        tx_cnt <= 2'd0;
      end else if ((tx_state == TX_WAIT) && tx_ready && (tx_cnt != 2'd3)) begin
        tx_cnt <= tx_cnt + 2'd1;
      end
    end
  end

  // Bytes leave least-significant first; WAIT ends on the transmitter's ready rise.
  always_comb begin
    tx_state_d = tx_state;
    tx_start   = 1'b0;
    tx_byte    = word[{tx_cnt, 3'b000} +: 8];
    case (tx_state)
      TX_IDLE: if (handshake) tx_state_d = TX_LOAD;
      TX_LOAD: tx_state_d = TX_SEND;
      TX_SEND: begin
        tx_start = 1'b1;
        if (!tx_ready) tx_state_d = TX_WAIT;
      end
      TX_WAIT: if (tx_ready) tx_state_d = (tx_cnt == 2'd3) ? TX_IDLE : TX_SEND;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      dump_busy <= 1'b0;
      dump_done <= 1'b0;
      timeout   <= 1'b0;
      byte_idx  <= 7'd0;
      tmo_cnt   <= '0;
    end else begin
      dump_done <= last_byte;
      timeout   <= timeout_hit;
      if (last_sent)                     dump_busy <= 1'b1;
      else if (timeout_hit || last_byte) dump_busy <= 1'b0;
      if (!dump_busy || accept) tmo_cnt <= '0;
      else                      tmo_cnt <= tmo_cnt + TW'(1);
      if (timeout_hit)  byte_idx <= 7'd0;
      else if (accept)  byte_idx <= byte_idx + 7'd1;
    end
  end

  // Register n occupies dump bytes 4n..4n+3, least-significant byte first.
  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) image[i] <= 32'd0;
      rd_data <= 32'd0;
    end else begin
      if (accept) image[byte_idx[6:2]][{byte_idx[1:0], 3'b000} +: 8] <= rx_byte;
      rd_data <= image[rd_addr];
    end
  end

endmodule

// File: tb/tb_uart_host_link.sv
// Randomised bench for uart_host_link: UART byte model on both lines, image reference model.
module tb_uart_host_link;

  localparam int BAUD = 8;
  localparam int TMO  = 1000;

  logic        clk12 = 1'b0;
  logic        rstn = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] inst_data = 32'd0;
  logic        inst_valid = 1'b0;
  logic [4:0]  rd_addr = 5'd0;
  logic        tx, inst_ready, dump_busy, dump_done, timeout, frame_err;
  logic [31:0] rd_data;

  int n_cmp = 0;
  int n_err = 0;
  int done_pulses = 0;
  int tmo_pulses = 0;
  int ferr_pulses = 0;
  int arm_count = 0;
  int closed_count = 0;
  int ready_viol = 0;
  logic [31:0] model_img [32];

  uart_host_link #(.BAUDRATE(BAUD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk12      (clk12),
    .rstn       (rstn),
    .rx         (rx),
    .tx         (tx),
    .inst_data  (inst_data),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .timeout    (timeout),
    .frame_err  (frame_err)
  );

  always #5 clk12 = ~clk12;

  // Pulse counters plus the rule that inst_ready stays low from accept until the dump ends.
  always @(negedge clk12) begin
    if (rstn) begin
      if (dump_done) done_pulses++;
      if (timeout)   tmo_pulses++;
      if (frame_err) ferr_pulses++;
    end
    if (!rstn || dump_done || timeout) closed_count = arm_count;
    else if (arm_count != closed_count && inst_ready) ready_viol++;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_write(input int n, input logic [7:0] b);
    model_img[n / 4][(n % 4) * 8 +: 8] = b;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk12);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk12);
    end
    rx = good_stop;
    repeat (BAUD) @(negedge clk12);
    rx = 1'b1;
    repeat (2) @(negedge clk12);
  endtask

  task automatic get_tx_byte(output logic [7:0] b, output bit ok);
    int w = 0;
    b  = 8'd0;
    ok = 1'b0;
    while (tx !== 1'b0 && w < 400) begin @(negedge clk12); w++; end
    if (tx !== 1'b0) return;
    repeat (BAUD / 2) @(negedge clk12);
    if (tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (BAUD) @(negedge clk12);
      b[i] = tx;
    end
    repeat (BAUD) @(negedge clk12);
    ok = (tx === 1'b1);
  endtask

  task automatic send_instruction(input logic [31:0] inst, output logic [31:0] got,
                                  output bit acc, output bit frames_ok, output bit ready_after,
                                  output bit busy_early, output bit busy_rose);
    int w = 0;
    logic [7:0] b;
    bit ok;
    got = 32'd0; acc = 0; frames_ok = 1; ready_after = 1; busy_early = 1; busy_rose = 0;
    inst_data  = inst;
    inst_valid = 1'b1;
    while (!inst_ready && w < 50) begin @(negedge clk12); w++; end
    if (!inst_ready) begin inst_valid = 1'b0; return; end
    @(negedge clk12);
    acc = 1;
    arm_count++;
    ready_after = inst_ready;
    inst_valid  = 1'b0;
    inst_data   = $urandom;
    for (int k = 0; k < 4; k++) begin
      get_tx_byte(b, ok);
      got[8 * k +: 8] = b;
      frames_ok = frames_ok && ok;
    end
    busy_early = dump_busy;
    w = 0;
    while (!dump_busy && w < 3 * BAUD) begin @(negedge clk12); w++; end
    busy_rose = dump_busy;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk12);
    n_cmp++;
    if ({tx, inst_ready, dump_busy, dump_done, timeout, frame_err} !== 6'b100000) begin
      n_err++;
      $display("[TB] FAIL reset_flags: got %b want 100000",
               {tx, inst_ready, dump_busy, dump_done, timeout, frame_err});
    end
    n_cmp++;
    if (rd_data !== 32'd0) begin
      n_err++; $display("[TB] FAIL reset_rd_data: got %h want 00000000", rd_data);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk12);
    n_cmp++;
    if (inst_ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL reset_release_ready: got %b want 1", inst_ready);
    end
    for (int r = 0; r < 32; r++) model_img[r] = 32'd0;
    for (int r = 0; r < 32; r++) begin
      rd_addr = 5'(r);
      @(negedge clk12);
      n_cmp++;
      if (rd_data !== model_img[r]) begin
        n_err++; $display("[TB] FAIL reset_image[%0d]: got %h want %h", r, rd_data, model_img[r]);
      end
    end
  endtask

  task automatic test_inst_tx();
    logic [31:0] got;
    bit acc, fok, rdy, early, rose;
    send_instruction(32'h00500093, got, acc, fok, rdy, early, rose);
    n_cmp++;
    if (!acc) begin n_err++; $display("[TB] FAIL inst_accept: got 0 want 1"); end
    n_cmp++;
    if (got !== 32'h00500093) begin
      n_err++; $display("[TB] FAIL inst_bytes: got %h want 00500093", got);
    end
    n_cmp++;
    if (!fok) begin n_err++; $display("[TB] FAIL inst_framing: got bad want good"); end
    n_cmp++;
    if (rdy !== 1'b0) begin n_err++; $display("[TB] FAIL ready_after_accept: got %b want 0", rdy); end
    n_cmp++;
    if (early !== 1'b0) begin
      n_err++; $display("[TB] FAIL busy_before_stop_end: got %b want 0", early);
    end
    n_cmp++;
    if (rose !== 1'b1) begin n_err++; $display("[TB] FAIL busy_rise: got %b want 1", rose); end
  endtask

  task automatic test_dump();
    int d0 = done_pulses;
    logic [7:0] b;
    for (int n = 0; n < 128; n++) begin
      b = (n == 4) ? 8'h05 : 8'h00;
      send_byte(b, 1'b1);
      model_write(n, b);
    end
    repeat (10) @(negedge clk12);
    n_cmp++;
    if (done_pulses - d0 != 1) begin
      n_err++; $display("[TB] FAIL dump_done_count: got %0d want 1", done_pulses - d0);
    end
    n_cmp++;
    if ({dump_busy, inst_ready} !== 2'b01) begin
      n_err++; $display("[TB] FAIL dump_end_flags: got %b want 01", {dump_busy, inst_ready});
    end
    n_cmp++;
    if (ready_viol != 0) begin
      n_err++; $display("[TB] FAIL ready_held_low: got %0d violations want 0", ready_viol);
    end
    rd_addr = 5'd1;
    @(negedge clk12);
    n_cmp++;
    if (rd_data !== 32'h00000005) begin
      n_err++; $display("[TB] FAIL read_x1: got %h want 00000005", rd_data);
    end
    for (int r = 0; r < 32; r++) begin
      rd_addr = 5'(r);
      @(negedge clk12);
      n_cmp++;
      if (rd_data !== model_img[r]) begin
        n_err++; $display("[TB] FAIL dump_image[%0d]: got %h want %h", r, rd_data, model_img[r]);
      end
    end
  endtask

  task automatic test_outside_dump();
    int d0 = done_pulses;
    for (int k = 0; k < 6; k++) send_byte(8'($urandom_range(1, 255)), 1'b1);
    repeat (10) @(negedge clk12);
    n_cmp++;
    if (done_pulses != d0 || dump_busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL idle_rx_flags: got done=%0d busy=%b want done=0 busy=0",
               done_pulses - d0, dump_busy);
    end
    for (int r = 0; r < 32; r++) begin
      rd_addr = 5'(r);
      @(negedge clk12);
      n_cmp++;
      if (rd_data !== model_img[r]) begin
        n_err++; $display("[TB] FAIL idle_image[%0d]: got %h want %h", r, rd_data, model_img[r]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] inst, got;
    logic [7:0] b;
    bit acc, fok, rdy, early, rose;
    int w = 0;
    int d0;
    inst = $urandom;
    send_instruction(inst, got, acc, fok, rdy, early, rose);
    n_cmp++;
    if (got !== inst || !rose) begin
      n_err++; $display("[TB] FAIL tmo_inst: got %h busy=%b want %h busy=1", got, rose, inst);
    end
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      model_write(n, b);
    end
    while (timeout !== 1'b1 && w < 2000) begin @(negedge clk12); w++; end
    n_cmp++;
    if (timeout !== 1'b1 || w < 970 || w > 1010) begin
      n_err++; $display("[TB] FAIL timeout_delay: got %0d cycles want about %0d", w, TMO);
    end
    n_cmp++;
    if ({dump_busy, inst_ready} !== 2'b01) begin
      n_err++; $display("[TB] FAIL timeout_flags: got %b want 01", {dump_busy, inst_ready});
    end
    for (int r = 0; r < 32; r++) begin
      rd_addr = 5'(r);
      @(negedge clk12);
      n_cmp++;
      if (rd_data !== model_img[r]) begin
        n_err++; $display("[TB] FAIL partial_image[%0d]: got %h want %h", r, rd_data, model_img[r]);
      end
    end
    inst = $urandom;
    send_instruction(inst, got, acc, fok, rdy, early, rose);
    d0 = done_pulses;
    for (int n = 0; n < 128; n++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      model_write(n, b);
    end
    repeat (10) @(negedge clk12);
    n_cmp++;
    if (done_pulses - d0 != 1) begin
      n_err++; $display("[TB] FAIL redump_done: got %0d want 1", done_pulses - d0);
    end
    for (int r = 0; r < 32; r++) begin
      rd_addr = 5'(r);
      @(negedge clk12);
      n_cmp++;
      if (rd_data !== model_img[r]) begin
        n_err++; $display("[TB] FAIL redump_image[%0d]: got %h want %h", r, rd_data, model_img[r]);
      end
    end
  endtask

  task automatic test_frame_err();
    logic [31:0] inst, got;
    logic [7:0] b;
    bit acc, fok, rdy, early, rose;
    int slot = 0;
    int w = 0;
    int d0, f0;
    inst = $urandom;
    send_instruction(inst, got, acc, fok, rdy, early, rose);
    d0 = done_pulses;
    f0 = ferr_pulses;
    for (int k = 0; k < 128; k++) begin
      b = 8'($urandom);
      if (k == 10) begin
        send_byte(b, 1'b0);
      end else begin
        send_byte(b, 1'b1);
        model_write(slot, b);
        slot++;
      end
    end
    while (timeout !== 1'b1 && w < 2000) begin @(negedge clk12); w++; end
    n_cmp++;
    if (timeout !== 1'b1) begin n_err++; $display("[TB] FAIL ferr_timeout: got 0 want 1"); end
    n_cmp++;
    if (ferr_pulses - f0 != 1 || done_pulses != d0) begin
      n_err++;
      $display("[TB] FAIL ferr_counts: got ferr=%0d done=%0d want ferr=1 done=0",
               ferr_pulses - f0, done_pulses - d0);
    end
    for (int r = 0; r < 32; r++) begin
      rd_addr = 5'(r);
      @(negedge clk12);
      n_cmp++;
      if (rd_data !== model_img[r]) begin
        n_err++; $display("[TB] FAIL ferr_image[%0d]: got %h want %h", r, rd_data, model_img[r]);
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] inst, got;
    logic [7:0] b;
    bit ok, acc, fok, rdy, early, rose;
    int w = 0;
    inst_data  = 32'h5AC300A5;
    inst_valid = 1'b1;
    while (!inst_ready && w < 50) begin @(negedge clk12); w++; end
    @(negedge clk12);
    inst_valid = 1'b0;
    get_tx_byte(b, ok);
    n_cmp++;
    if (b !== 8'hA5 || !ok) begin
      n_err++; $display("[TB] FAIL rst_first_byte: got %h want a5", b);
    end
    w = 0;
    while (tx !== 1'b0 && w < 400) begin @(negedge clk12); w++; end
    repeat (2 * BAUD) @(negedge clk12);
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({tx, inst_ready, dump_busy} !== 3'b100) begin
      n_err++; $display("[TB] FAIL rst_mid_flags: got %b want 100", {tx, inst_ready, dump_busy});
    end
    repeat (3) @(negedge clk12);
    rstn = 1'b1;
    repeat (2) @(negedge clk12);
    n_cmp++;
    if (inst_ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL rst_release_ready: got %b want 1", inst_ready);
    end
    for (int r = 0; r < 32; r++) model_img[r] = 32'd0;
    for (int r = 0; r < 32; r++) begin
      rd_addr = 5'(r);
      @(negedge clk12);
      n_cmp++;
      if (rd_data !== model_img[r]) begin
        n_err++; $display("[TB] FAIL rst_image[%0d]: got %h want %h", r, rd_data, model_img[r]);
      end
    end
    inst = $urandom;
    send_instruction(inst, got, acc, fok, rdy, early, rose);
    n_cmp++;
    if (got !== inst || !fok || !rose) begin
      n_err++;
      $display("[TB] FAIL rst_fresh_inst: got %h frames=%b busy=%b want %h frames=1 busy=1",
               got, fok, rose, inst);
    end
    w = 0;
    while (timeout !== 1'b1 && w < 2000) begin @(negedge clk12); w++; end
    n_cmp++;
    if (timeout !== 1'b1) begin n_err++; $display("[TB] FAIL rst_final_timeout: got 0 want 1"); end
  endtask

  initial begin
    test_reset();
    test_inst_tx();
    test_dump();
    test_outside_dump();
    test_timeout();
    test_frame_err();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
